// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin arbitrated JK state bank with one-cycle command stage and ack
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic [NREQ-1:0]      REQ_VALID,
  input  logic [2*NREQ-1:0]    REQ_OP,
  input  logic [IDXW*NREQ-1:0] REQ_IDX,
  output logic [NREQ-1:0]      REQ_READY,
  output logic [NBITS-1:0]     Q,
  output logic                 ACK_VALID,
  output logic [2:0]           ACK_ID,
  output logic                 ACK_OLD,
  output logic                 ACK_ERR
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] OP_SET    = 2'd1;
  localparam logic [1:0] OP_RESET  = 2'd2;
  localparam logic [1:0] OP_TOGGLE = 2'd3;
  localparam logic [IDXW:0] NB = (IDXW+1)'(NBITS);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx;
  logic             found;
  logic             accept;
  logic [NREQ-1:0]  rot;
  logic [PW:0]      sum;
  logic [1:0]       sel_op;
  logic [IDXW-1:0]  sel_idx;

  logic             st_valid;
  logic [1:0]       st_op;
  logic [IDXW-1:0]  st_idx;
  logic [PW-1:0]    st_id;
  logic             in_range;
  logic [NBITS-1:0] mask;
  logic             old_bit;
  logic [NBITS-1:0] q_next;

  // Rotate valids so bit 0 is the requester at the pointer, then take the first set bit.
  always_comb begin
    rot   = NREQ'({REQ_VALID, REQ_VALID} >> ptr);
    found = 1'b0;
    gidx  = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (PW+1)'(k);
        if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
        gidx  = sum[PW-1:0];
      end
    end
    accept    = EN && found;
    REQ_READY = accept ? (NREQ'(1) << gidx) : '0;
  end

  always_comb begin
    sel_op  = '0;
    sel_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (REQ_READY[k]) begin
        sel_op  = REQ_OP[2*k +: 2];
        sel_idx = REQ_IDX[IDXW*k +: IDXW];
      end
    end
  end

  // An out-of-range index yields an empty mask, so Q is left untouched and old reads 0.
  always_comb begin
    in_range = {1'b0, st_idx} < NB;
    mask     = in_range ? (NBITS'(1) << st_idx) : '0;
    old_bit  = |(Q & mask);
    case (st_op)
      OP_SET:    q_next = Q | mask;
      OP_RESET:  q_next = Q & ~mask;
      OP_TOGGLE: q_next = Q ^ mask;
      default:   q_next = Q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr       <= '0;
      st_valid  <= 1'b0;
      st_op     <= '0;
      st_idx    <= '0;
      st_id     <= '0;
      Q         <= '0;
      ACK_VALID <= 1'b0;
      ACK_ID    <= '0;
      ACK_OLD   <= 1'b0;
      ACK_ERR   <= 1'b0;
    end else begin
      st_valid  <= accept;
      if (accept) begin
        st_op  <= sel_op;
        st_idx <= sel_idx;
        st_id  <= gidx;
        ptr    <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
      end
      ACK_VALID <= st_valid;
      if (st_valid) begin
        Q       <= q_next;
        ACK_ID  <= 3'(st_id);
        ACK_OLD <= old_bit;
        ACK_ERR <= !in_range;
      end
    end
  end

endmodule
